scalar_mul_sequencer: RTL and testbench
=======================================

// Module: scalar_mul_sequencer
// PURPOSE
//   Sequential, single-multiplier engine for matrix scalar multiply (up to 5x5, 8-bit elements).
//   Latches the operands on a start pulse, then walks the active m x n region row-major,
//   writing one product per clock into a result register. Sits between the menu/input FSM and
//   the display stage. Reports completion, or rejects illegal dimensions, with one-cycle pulses.
// PARAMETERS
//   MAX_DIM   5  max rows/cols; matrix bus = MAX_DIM*MAX_DIM*ELEM_W bits
//   ELEM_W    8  element width; element (i,j) sits at bits [(i*MAX_DIM+j)*ELEM_W +: ELEM_W]
//   SCALAR_W  4  scalar width (unsigned)
// PORTS
//   clk           in   1    clock, rising edge
//   reset         in   1    asynchronous, active-low reset (0 = reset)
//   start         in   1    request pulse; sampled only in IDLE
//   m             in   3    row count, legal 1..5
//   n             in   3    column count, legal 1..5
//   scalar_value  in   4    unsigned scalar
//   matrix_a      in   200  operand matrix, packed as above
//   busy          out  1    high while in RUN
//   done          out  1    one-cycle pulse: result complete
//   error         out  1    one-cycle pulse: start rejected (illegal m/n)
//   valid         out  1    level: result holds a completed product
//   scalar_mul    out  200  result matrix, same packing as matrix_a
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; busy, done, error, valid = 0; scalar_mul = 0; row/col = 0.
//   All outputs are registered. FSM states: IDLE, RUN.
//   IDLE, start=1 at edge E0:
//     - m or n == 0, or > 5: error<=1 for one cycle; valid<=0; scalar_mul<=0; stay IDLE.
//     - otherwise: latch m, n, scalar_value, matrix_a; scalar_mul<=0; valid<=0; row=col=0;
//       busy<=1; go to RUN.
//   RUN, edges E1..E(m*n): one element per edge,
//     scalar_mul[elem(row,col)] <= low ELEM_W bits of (A[row][col] * scalar) (mod 256, unsigned).
//     col increments; when col==n-1, col wraps to 0 and row increments.
//   At edge E(m*n) (last element, row==m-1, col==n-1): busy<=0, done<=1, valid<=1, go to IDLE.
//   done and error deassert on the following edge. Total latency start->done = m*n edges.
//   Elements outside the m x n region stay 0.
//   start while busy is ignored: no restart, no error, and no effect on latched operands.
//   Changes to m, n, scalar_value or matrix_a during RUN are ignored.
//   start on the cycle done is high is accepted (state is IDLE): valid drops, and a new run begins.
//   valid and scalar_mul hold until the next accepted start, an error, or reset.
//   Reset asserted mid-RUN aborts immediately to the reset values; no done pulse is produced.
//   Scalar 0 is legal: the run completes normally with zeros in the active region.
// TESTING
//   1. m=2,n=3, all A=8'd3, scalar=2, start -> busy 6 cycles; done pulse at E6; active elements 8'd6,
//      rest 0; valid=1.
//   2. m=5,n=5, all A=8'hFF, scalar=15 -> done at E25; all 25 elements 8'hF1 (truncation of 0xEF1).
//   3. m=0,n=3 start; then m=6,n=2 start -> error pulse 1 cycle each; busy stays 0; valid=0;
//      scalar_mul=0.
//   4. During run of m=3,n=3, pulse start with new m=1,n=1 and change matrix_a -> ignored;
//      done at E9 with original operands.
//   5. reset=0 at E4 of a 4x4 run -> outputs immediately 0, IDLE; after release, a new 1x1 start
//      gives done at E1.
//   6. start held high on the done cycle of a 2x2 run -> valid drops, second run starts;
//      second done at 4 edges later.

Source files
------------

// File: rtl/scalar_mul_sequencer.sv
// scalar_mul_sequencer
//   Sequential single-multiplier engine for matrix scalar multiply. On an
//   accepted start it latches the operands, then writes one product per clock
//   (row-major over the active m x n region) into the result register.
//
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   start        : run request, sampled only while idle
//   m, n         : active rows / columns, legal 1..MAX_DIM
//   scalar_value : unsigned scalar multiplier
//   matrix_a     : operand, element (i,j) at [(i*MAX_DIM+j)*ELEM_W +: ELEM_W]
//   busy         : high while running
//   done         : one-cycle pulse when the result is complete
//   error        : one-cycle pulse when a start is rejected (illegal m/n)
//   valid        : result holds a completed product
//   scalar_mul   : result matrix, same packing as matrix_a
module scalar_mul_sequencer #(
    parameter int unsigned MAX_DIM  = 5,
    parameter int unsigned ELEM_W   = 8,
    parameter int unsigned SCALAR_W = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2:0]                        m,
    input  logic [2:0]                        n,
    input  logic [SCALAR_W-1:0]               scalar_value,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_a,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic                              valid,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] scalar_mul
);

    localparam int unsigned MAT_W = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int unsigned OFF_W = $clog2(MAT_W);
    localparam int unsigned DIM_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DIM_W-1:0]    m_q, m_d;
    logic [DIM_W-1:0]    n_q, n_d;
    logic [DIM_W-1:0]    row_q, row_d;
    logic [DIM_W-1:0]    col_q, col_d;
    logic [SCALAR_W-1:0] scalar_q, scalar_d;
    logic [MAT_W-1:0]    mat_q, mat_d;
    logic [MAT_W-1:0]    res_q, res_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                valid_q, valid_d;

    logic [OFF_W-1:0]    bit_off_c;
    logic [ELEM_W-1:0]   a_elem_c;
    logic                dims_ok_c;

    // Bit offset of the element currently being processed
    assign bit_off_c = (OFF_W'(row_q) * OFF_W'(MAX_DIM) + OFF_W'(col_q)) * OFF_W'(ELEM_W);
    assign a_elem_c  = mat_q[bit_off_c +: ELEM_W];

    assign dims_ok_c = (m != '0) && (m <= DIM_W'(MAX_DIM)) &&
                       (n != '0) && (n <= DIM_W'(MAX_DIM));

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        row_d    = row_q;
        col_d    = col_q;
        scalar_d = scalar_q;
        mat_d    = mat_q;
        res_d    = res_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    valid_d = 1'b0;
                    res_d   = '0;
                    if (dims_ok_c) begin
                        m_d      = m;
                        n_d      = n;
                        scalar_d = scalar_value;
                        mat_d    = matrix_a;
                        row_d    = '0;
                        col_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Product truncated to ELEM_W bits (mod 2^ELEM_W)
                res_d[bit_off_c +: ELEM_W] = a_elem_c * ELEM_W'(scalar_q);
                if (col_q == n_q - DIM_W'(1)) begin
                    col_d = '0;
                    if (row_q == m_q - DIM_W'(1)) begin
                        row_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + DIM_W'(1);
                    end
                end else begin
                    col_d = col_q + DIM_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            n_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            scalar_q <= '0;
            mat_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            n_q      <= n_d;
            row_q    <= row_d;
            col_q    <= col_d;
            scalar_q <= scalar_d;
            mat_q    <= mat_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign valid      = valid_q;
    assign scalar_mul = res_q;

endmodule

// File: tb/tb_scalar_mul_sequencer.sv
// Bench for scalar_mul_sequencer: a transaction-level model predicts every
// output each cycle, and directed runs pin latencies and element values.
module tb_scalar_mul_sequencer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   m = '0;
    logic [2:0]   n = '0;
    logic [3:0]   scalar_value = '0;
    logic [199:0] matrix_a = '0;
    logic         busy, done, error, valid;
    logic [199:0] scalar_mul;

    int checks = 0;
    int errors = 0;

    scalar_mul_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .m            (m),
        .n            (n),
        .scalar_value (scalar_value),
        .matrix_a     (matrix_a),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .valid        (valid),
        .scalar_mul   (scalar_mul)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] mdl_a   [25];
    logic [7:0] mdl_res [25];
    int         mdl_m = 0, mdl_n = 0, mdl_s = 0;
    int         mdl_cnt = 0;
    logic       mdl_busy = 0, mdl_done = 0, mdl_err = 0, mdl_valid = 0;

    initial for (int k = 0; k < 25; k++) begin mdl_a[k] = '0; mdl_res[k] = '0; end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_busy = 0; mdl_done = 0; mdl_err = 0; mdl_valid = 0; mdl_cnt = 0;
            for (int k = 0; k < 25; k++) mdl_res[k] = '0;
        end else begin
            mdl_done = 0;
            mdl_err  = 0;
            if (mdl_busy) begin
                int r, c;
                r = mdl_cnt / mdl_n;
                c = mdl_cnt % mdl_n;
                mdl_res[r*5+c] = 8'((int'(mdl_a[r*5+c]) * mdl_s) % 256);
                mdl_cnt++;
                if (mdl_cnt == mdl_m * mdl_n) begin
                    mdl_busy = 0; mdl_done = 1; mdl_valid = 1;
                end
            end else if (start) begin
                mdl_valid = 0;
                for (int k = 0; k < 25; k++) mdl_res[k] = '0;
                if (m >= 1 && m <= 5 && n >= 1 && n <= 5) begin
                    mdl_m = int'(m); mdl_n = int'(n); mdl_s = int'(scalar_value);
                    for (int k = 0; k < 25; k++) mdl_a[k] = matrix_a[k*8 +: 8];
                    mdl_cnt = 0;
                    mdl_busy = 1;
                end else begin
                    mdl_err = 1;
                end
            end
        end
    end

    function automatic logic [199:0] mdl_pack();
        logic [199:0] v;
        for (int k = 0; k < 25; k++) v[k*8 +: 8] = mdl_res[k];
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] el(input int r, input int c);
        logic [199:0] v;
        v = scalar_mul;
        return v[(r*5+c)*8 +: 8];
    endfunction

    function automatic logic [199:0] fill_const(input logic [7:0] v);
        logic [199:0] x;
        for (int k = 0; k < 25; k++) x[k*8 +: 8] = v;
        return x;
    endfunction

    function automatic logic [199:0] fill_seq();
        logic [199:0] x;
        for (int k = 0; k < 25; k++) x[k*8 +: 8] = 8'(k + 1);
        return x;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy",  {31'd0, busy},  {31'd0, mdl_busy});
        chk("done",  {31'd0, done},  {31'd0, mdl_done});
        chk("error", {31'd0, error}, {31'd0, mdl_err});
        chk("valid", {31'd0, valid}, {31'd0, mdl_valid});
        checks++;
        if (scalar_mul !== mdl_pack()) begin
            errors++;
            $display("FAIL scalar_mul: got %h expected %h at %0t", scalar_mul, mdl_pack(), $time);
        end
    end

    // Starts a run at the current negedge and waits for done.
    // inj_at > 0: at that edge pulse start with different operands.
    task automatic do_run(input int mm, input int nn, input int ss, input logic [199:0] a,
                          input int inj_at, output int lat, output int busy_cnt);
        start = 1'b1; m = 3'(mm); n = 3'(nn); scalar_value = 4'(ss); matrix_a = a;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy",  {31'd0, busy},  32'd1);
        chk("accept_valid", {31'd0, valid}, 32'd0);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (inj_at > 0 && lat == inj_at) begin
                start = 1'b1; m = 3'd1; n = 3'd1; scalar_value = 4'd7; matrix_a = fill_const(8'hAA);
            end
            if (inj_at > 0 && lat == inj_at + 1) start = 1'b0;
        end
    endtask

    task automatic do_err(input int mm, input int nn);
        start = 1'b1; m = 3'(mm); n = 3'(nn);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", {31'd0, error}, 32'd1);
        chk("err_busy",  {31'd0, busy},  32'd0);
        chk("err_valid", {31'd0, valid}, 32'd0);
        chk("err_res_zero", {31'd0, (scalar_mul == '0)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("err_drop", {31'd0, error}, 32'd0);
        chk("err_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat, bc;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_res",   {31'd0, (scalar_mul == '0)}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // 2x3, all 3, scalar 2
        do_run(2, 3, 2, fill_const(8'd3), 0, lat, bc);
        chk("t1_latency", lat, 32'd6);
        chk("t1_busy_cycles", bc, 32'd6);
        chk("t1_valid", {31'd0, valid}, 32'd1);
        chk("t1_e00", {24'd0, el(0, 0)}, 32'd6);
        chk("t1_e12", {24'd0, el(1, 2)}, 32'd6);
        chk("t1_e03", {24'd0, el(0, 3)}, 32'd0);
        chk("t1_e20", {24'd0, el(2, 0)}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t1_valid_hold", {31'd0, valid}, 32'd1);

        // 5x5, all FF, scalar 15 -> 0xEF1 truncated
        do_run(5, 5, 15, fill_const(8'hFF), 0, lat, bc);
        chk("t2_latency", lat, 32'd25);
        chk("t2_e00", {24'd0, el(0, 0)}, 32'hF1);
        chk("t2_e44", {24'd0, el(4, 4)}, 32'hF1);
        chk("t2_e23", {24'd0, el(2, 3)}, 32'hF1);
        @(negedge clk);

        // Illegal dimensions
        do_err(0, 3);
        do_err(6, 2);
        do_err(3, 7);

        // Start during run ignored
        do_run(3, 3, 3, fill_seq(), 3, lat, bc);
        chk("t4_latency", lat, 32'd9);
        chk("t4_e00", {24'd0, el(0, 0)}, 32'd3);
        chk("t4_e22", {24'd0, el(2, 2)}, 32'd39);
        chk("t4_e11", {24'd0, el(1, 1)}, 32'd21);
        chk("t4_e03", {24'd0, el(0, 3)}, 32'd0);
        repeat (2) @(negedge clk);

        // Reset mid-run of 4x4
        start = 1'b1; m = 3'd4; n = 3'd4; scalar_value = 4'd1; matrix_a = fill_seq();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_busy",  {31'd0, busy},  32'd0);
        chk("t5_done",  {31'd0, done},  32'd0);
        chk("t5_valid", {31'd0, valid}, 32'd0);
        chk("t5_res",   {31'd0, (scalar_mul == '0)}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_no_done", {31'd0, done}, 32'd0);
        do_run(1, 1, 5, fill_const(8'd10), 0, lat, bc);
        chk("t5_latency", lat, 32'd1);
        chk("t5_e00", {24'd0, el(0, 0)}, 32'd50);

        // Back-to-back: start on the done cycle
        @(negedge clk);
        do_run(2, 2, 2, fill_seq(), 0, lat, bc);
        chk("t6_first_latency", lat, 32'd4);
        do_run(2, 2, 4, fill_const(8'd100), 0, lat, bc);
        chk("t6_second_latency", lat, 32'd4);
        chk("t6_e01", {24'd0, el(0, 1)}, 32'd144);
        chk("t6_e02", {24'd0, el(0, 2)}, 32'd0);

        // Scalar 0
        @(negedge clk);
        do_run(2, 2, 0, fill_seq(), 0, lat, bc);
        chk("t7_latency", lat, 32'd4);
        chk("t7_valid", {31'd0, valid}, 32'd1);
        chk("t7_zero", {31'd0, (scalar_mul == '0)}, 32'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
